// File: rtl/demux1x8_tdm_if.sv
// rtl/demux1x8_tdm_if.sv - serial slot stream into the 1:8 TDM demultiplexer
interface demux1x8_tdm_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sof;

    modport master (output din, output din_valid, output sof);
    modport slave  (input  din, input  din_valid, input  sof);
endinterface

// File: rtl/demux1x8_tdm.sv
// rtl/demux1x8_tdm.sv - 1:8 TDM demux with frame sync; DEMUX_FRAME_CNT_EN adds frame_cnt
module demux1x8_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    demux1x8_tdm_if.slave    link,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [2:0]       sel,
    output logic             frame_valid,
    output logic             sync_err
`ifdef DEMUX_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    typedef enum logic {HUNT, FILL} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sel_d;
    logic [WIDTH-1:0] shd_q [0:6];
    logic             shd_wr;
    logic [2:0]       shd_idx;
    logic             load;
    logic             err_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        shd_wr  = 1'b0;
        shd_idx = sel;
        load    = 1'b0;
        err_d   = 1'b0;
        if (link.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (link.sof) begin
                        shd_wr  = 1'b1;
                        shd_idx = 3'd0;
                        sel_d   = 3'd1;
                        state_d = FILL;
                    end
                end
                default: begin
                    if (link.sof) begin
                        // sof anywhere but slot 0 is a resync: restart the frame here
                        err_d   = (sel != 3'd0);
                        shd_wr  = 1'b1;
                        shd_idx = 3'd0;
                        sel_d   = 3'd1;
                    end else if (sel == 3'd0) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (sel == 3'd7) begin
                        load  = 1'b1;
                        sel_d = 3'd0;
                    end else begin
                        shd_wr = 1'b1;
                        sel_d  = sel + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            sel         <= 3'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            for (int i = 0; i < 7; i++) shd_q[i] <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
        end else begin
            state_q     <= state_d;
            sel         <= sel_d;
            frame_valid <= load;
            sync_err    <= err_d;
            for (int i = 0; i < 7; i++) begin
                if (shd_wr && shd_idx == 3'(i)) shd_q[i] <= link.din;
            end
            if (load) begin
                a <= shd_q[0];
                b <= shd_q[1];
                c <= shd_q[2];
                d <= shd_q[3];
                e <= shd_q[4];
                f <= shd_q[5];
                g <= shd_q[6];
                h <= link.din;
            end
        end
    end

`ifdef DEMUX_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)       frame_cnt <= 8'd0;
        else if (load) frame_cnt <= frame_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_demux1x8_tdm.sv
// tb/tb_demux1x8_tdm.sv - directed bench for demux1x8_tdm
module tb_demux1x8_tdm;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic [2:0]   sel;
    logic         frame_valid, sync_err;
    logic [31:0]  outs;
`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0]   frame_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    demux1x8_tdm_if #(.WIDTH(W)) link ();

    demux1x8_tdm #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .link(link.slave),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .sel(sel), .frame_valid(frame_valid), .sync_err(sync_err)
`ifdef DEMUX_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign outs = {a, b, c, d, e, f, g, h};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [W-1:0] x);
        @(negedge clk);
        link.din_valid = v;
        link.sof       = s;
        link.din       = x;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom_range(1)), W'($urandom_range(15)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        link.din_valid = 1'b0;
        link.sof = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends slot 0 from vals[31:28] through slot 7 from vals[3:0], with random idle gaps.
    task automatic send_frame(input logic [31:0] vals, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            int gap = (maxgap > 0) ? $urandom_range(maxgap) : 0;
            for (int k = 0; k < gap; k++) idle();
            step(1'b1, i == 0, vals[31 - 4*i -: 4]);
        end
    endtask

    initial begin
        int fv_cnt, fv_first, fv_second, se_cnt;
        logic [31:0] mid_outs;

        link.din = '0;
        link.din_valid = 1'b0;
        link.sof = 1'b0;
        do_reset();
        #1;
        chk("reset_outs", outs, 32'h0);
        chk("reset_sel", {29'd0, sel}, 32'd0);
        chk("reset_fv", {31'd0, frame_valid}, 32'd0);
        chk("reset_se", {31'd0, sync_err}, 32'd0);

        step(1'b1, 1'b1, 4'h1);
        chk("first_sel", {29'd0, sel}, 32'd1);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h1);
        chk("pre_load_fv", {31'd0, frame_valid}, 32'd0);
        chk("pre_load_outs", outs, 32'h0);
        step(1'b1, 1'b0, 4'h0);
        chk("frame1_fv", {31'd0, frame_valid}, 32'd1);
        chk("frame1_outs", outs, 32'h10110010);
        chk("frame1_sel", {29'd0, sel}, 32'd0);

        fv_cnt = 0; fv_first = -1; fv_second = -1; se_cnt = 0; mid_outs = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 8) == 0, (i < 8) ? W'(i + 2) : 4'hF);
            if (sync_err) se_cnt++;
            if (frame_valid) begin
                if (fv_cnt == 0) begin fv_first = i; mid_outs = outs; end
                else fv_second = i;
                fv_cnt++;
            end
        end
        chk("b2b_pulses", fv_cnt, 32'd2);
        chk("b2b_first_at", fv_first, 32'd7);
        chk("b2b_second_at", fv_second, 32'd15);
        chk("b2b_mid_outs", mid_outs, 32'h23456789);
        chk("b2b_outs", outs, 32'hFFFFFFFF);
        chk("b2b_no_err", se_cnt, 32'd0);
        step(1'b0, 1'b0, 4'h0);
        chk("fv_one_cycle", {31'd0, frame_valid}, 32'd0);

        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        step(1'b1, 1'b0, 4'h4);
        chk("pre_early_sel", {29'd0, sel}, 32'd4);
        step(1'b1, 1'b1, 4'hA);
        chk("early_sof_se", {31'd0, sync_err}, 32'd1);
        chk("early_sof_fv", {31'd0, frame_valid}, 32'd0);
        chk("early_sof_sel", {29'd0, sel}, 32'd1);
        chk("early_sof_outs", outs, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 4'hB);
        chk("se_one_cycle", {31'd0, sync_err}, 32'd0);
        step(1'b1, 1'b0, 4'hC);
        step(1'b1, 1'b0, 4'hD);
        step(1'b1, 1'b0, 4'hE);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        chk("resync_fv", {31'd0, frame_valid}, 32'd1);
        chk("resync_outs", outs, 32'hABCDE123);

        step(1'b1, 1'b0, 4'h5);
        chk("slot0_nosof_se", {31'd0, sync_err}, 32'd1);
        chk("slot0_nosof_sel", {29'd0, sel}, 32'd0);
        chk("slot0_nosof_outs", outs, 32'hABCDE123);
        step(1'b1, 1'b0, 4'h6);
        chk("hunt_drop_se", {31'd0, sync_err}, 32'd0);
        chk("hunt_drop_sel", {29'd0, sel}, 32'd0);
        step(1'b1, 1'b0, 4'h7);
        chk("hunt_stays_sel", {29'd0, sel}, 32'd0);

        step(1'b1, 1'b1, 4'h9);
        step(1'b1, 1'b0, 4'h9);
        step(1'b1, 1'b0, 4'h9);
        step(1'b1, 1'b0, 4'h9);
        step(1'b1, 1'b0, 4'h9);
        chk("pre_rst_sel", {29'd0, sel}, 32'd5);
        do_reset();
        #1;
        chk("midrst_outs", outs, 32'h0);
        chk("midrst_sel", {29'd0, sel}, 32'd0);
        chk("midrst_fv", {31'd0, frame_valid}, 32'd0);
        send_frame(32'h76543210, 3);
        chk("gap_fv", {31'd0, frame_valid}, 32'd1);
        chk("gap_outs", outs, 32'h76543210);
        idle();
        chk("gap_sel_idle", {29'd0, sel}, 32'd0);
        send_frame(32'h13579BDF, 0);
        chk("clean_outs", outs, 32'h13579BDF);

`ifdef DEMUX_FRAME_CNT_EN
        chk("cnt_before", {24'd0, frame_cnt}, 32'd2);
        do_reset();
        #1;
        chk("cnt_reset", {24'd0, frame_cnt}, 32'd0);
        for (int n = 0; n < 257; n++) send_frame(32'h01234567 + n, 0);
        chk("cnt_257", {24'd0, frame_cnt}, 32'd1);
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b1, 4'h3);
        chk("cnt_resync_se", {31'd0, sync_err}, 32'd1);
        chk("cnt_resync", {24'd0, frame_cnt}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
